// File: rtl/trigger_capture_ctrl.sv
// Capture sequencer: fills pre-trigger history, arms the channel stages, waits for the
// combined trigger, stores trig_pos post-trigger samples into the circular RAM, flags done.
module trigger_capture_ctrl #(
    parameter int unsigned ENTRIES = 384,
    localparam int unsigned AW = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    ChTrig,
    input  logic          run,
    input  logic [AW-1:0] trig_pos,
    input  logic          wrt_smpl,
    input  logic          clr_done,
    output logic          set_armed,
    output logic          triggered,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] trig_addr,
    output logic          capture_done
);

    // Sample counter needs one extra bit: it may reach ENTRIES when tpos is 0.
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRETRIG,
        S_ARMED,
        S_POSTTRIG,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] waddr_nxt, waddr_inc;
    logic [AW-1:0] trig_addr_nxt;
    logic [AW-1:0] tpos, tpos_nxt;
    logic [AW-1:0] post_cnt, post_nxt;
    logic [CW-1:0] smpl_cnt, smpl_nxt;
    logic          triggered_nxt, done_nxt;
    logic          trig_all;

    assign trig_all  = &ChTrig;
    assign waddr_inc = (waddr == LAST) ? '0 : waddr + AW'(1);
    assign we        = wrt_smpl & ((state == S_PRETRIG) | (state == S_ARMED) | (state == S_POSTTRIG));

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            waddr        <= '0;
            trig_addr    <= '0;
            tpos         <= '0;
            post_cnt     <= '0;
            smpl_cnt     <= '0;
            triggered    <= 1'b0;
            capture_done <= 1'b0;
            set_armed    <= 1'b0;
        end else begin
            state        <= state_nxt;
            waddr        <= waddr_nxt;
            trig_addr    <= trig_addr_nxt;
            tpos         <= tpos_nxt;
            post_cnt     <= post_nxt;
            smpl_cnt     <= smpl_nxt;
            triggered    <= triggered_nxt;
            capture_done <= done_nxt;
            set_armed    <= (state_nxt == S_ARMED);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt     = state;
        waddr_nxt     = waddr;
        trig_addr_nxt = trig_addr;
        tpos_nxt      = tpos;
        post_nxt      = post_cnt;
        smpl_nxt      = smpl_cnt;
        triggered_nxt = triggered;
        done_nxt      = capture_done;

        if (we) begin
            waddr_nxt = waddr_inc;
        end

        case (state)
            S_IDLE: begin
                smpl_nxt = '0;
                tpos_nxt = (trig_pos > LAST) ? LAST : trig_pos;
                if (run) begin
                    state_nxt = S_PRETRIG;
                end
            end
            S_PRETRIG: begin
                if (!run) begin
                    state_nxt = S_IDLE;
                end else if (wrt_smpl) begin
                    smpl_nxt = smpl_cnt + CW'(1);
                    if (smpl_nxt == CW'(ENTRIES) - CW'(tpos)) begin
                        state_nxt = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (!run) begin
                    state_nxt     = S_IDLE;
                    triggered_nxt = 1'b0;
                end else if (trig_all) begin
                    triggered_nxt = 1'b1;
                    trig_addr_nxt = waddr_nxt;
                    post_nxt      = '0;
                    if (tpos == '0) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_POSTTRIG;
                    end
                end
            end
            S_POSTTRIG: begin
                if (!run) begin
                    state_nxt     = S_IDLE;
                    triggered_nxt = 1'b0;
                end else if (wrt_smpl) begin
                    post_nxt = post_cnt + AW'(1);
                    if (post_nxt == tpos) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (clr_done) begin
                    state_nxt     = S_IDLE;
                    done_nxt      = 1'b0;
                    triggered_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Every return to IDLE starts the next capture from address 0.
        if (state_nxt == S_IDLE) begin
            waddr_nxt = '0;
            smpl_nxt  = '0;
        end
    end

endmodule
